mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: shares one word memory between fetch and load/store ports,  |
// | with WAIT_CYCLES wait states. Define MEM_ARB_RR_EN for round-robin ties. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] INST_BASE   = 32'h3000,
  parameter logic [31:0] MEM_SIZE    = 32'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [3:0]  c_WAIT      = 4'(WAIT_CYCLES);
  localparam logic [31:0] c_DATA_LAST = INST_BASE - 32'd4;
  localparam logic [31:0] c_INST_LAST = MEM_SIZE - 32'd4;
  localparam logic        c_OWN_IF    = 1'b0;
  localparam logic        c_OWN_D     = 1'b1;

  state_e      state_q;
  logic        owner_q;
  logic        we_q;
  logic        last_owner_q;
  logic [3:0]  cnt_q;
  logic        err_q;
  logic        if_done_q;
  logic        d_done_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic        gnt_if_d;
  logic        gnt_we_d;
  logic        gnt_valid_d;
  logic [31:0] gnt_addr_d;

  always_comb begin
    gnt_if_d = if_req;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      gnt_if_d = (last_owner_q == c_OWN_D);
`else
      gnt_if_d = 1'b0;
`endif
    end
    gnt_addr_d = gnt_if_d ? if_addr : d_addr;
    gnt_we_d   = !gnt_if_d && d_we;
    if (gnt_if_d) begin
      gnt_valid_d = (gnt_addr_d[1:0] == 2'b00) && (gnt_addr_d >= INST_BASE) &&
                    (gnt_addr_d <= c_INST_LAST);
    end else begin
      gnt_valid_d = (gnt_addr_d[1:0] == 2'b00) && (gnt_addr_d <= c_DATA_LAST);
    end
  end

`ifndef MEM_ARB_RR_EN
  // last_owner is still tracked in fixed-priority builds but never consulted.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= c_OWN_D;
      we_q         <= 1'b0;
      last_owner_q <= c_OWN_D;
      cnt_q        <= 4'd0;
      err_q        <= 1'b0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
    end else begin
      err_q     <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req || d_req) begin
            owner_q      <= gnt_if_d ? c_OWN_IF : c_OWN_D;
            last_owner_q <= gnt_if_d ? c_OWN_IF : c_OWN_D;
            we_q         <= gnt_we_d;
            cnt_q        <= c_WAIT;
            if (gnt_valid_d) begin
              mem_addr_q  <= gnt_addr_d;
              mem_read_q  <= !gnt_we_d;
              mem_write_q <= gnt_we_d;
              if (gnt_we_d) begin
                mem_wdata_q <= d_wdata;
              end
              state_q <= S_ACCESS;
            end else begin
              // Rejected: report immediately, memory strobes stay low.
              err_q     <= 1'b1;
              if_done_q <= gnt_if_d;
              d_done_q  <= !gnt_if_d;
              state_q   <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == 4'd0) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (!we_q) begin
              if (owner_q == c_OWN_IF) begin
                if_rdata_q <= mem_rdata;
              end else begin
                d_rdata_q <= mem_rdata;
              end
            end
            if_done_q <= (owner_q == c_OWN_IF);
            d_done_q  <= (owner_q == c_OWN_D);
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = (err_q && if_done_q) ? 32'd0 : if_rdata_q;
  assign d_rdata   = (err_q && d_done_q) ? 32'd0 : d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: directed and randomized checks of mem_arbiter against a  |
// | word-array memory model. Rev 1.0                                         |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int          W  = 2;
  localparam logic [31:0] IB = 32'h3000;
  localparam logic [31:0] MS = 32'h4000;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] exp_if_last;
  logic [31:0] exp_d_last;

  mem_arbiter #(.WAIT_CYCLES(W), .INST_BASE(IB), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int i);
    return (i == 32'hC00) ? 32'h20080005 : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  // Memory seen by the DUT: asynchronous read, written on the clock edge.
  initial for (int i = 0; i < 4096; i++) mem[i] <= pattern(i);
  always @(posedge clk) if (mem_write) mem[mem_addr[13:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[13:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_valid(input bit is_if, input logic [31:0] a);
    longint la;
    la = longint'({32'd0, a});
    if (la % 4 != 0) return 1'b0;
    if (is_if) return (la >= longint'({32'd0, IB})) && (la + 4 <= longint'({32'd0, MS}));
    return la + 4 <= longint'({32'd0, IB});
  endfunction

  task automatic reset_seq();
    @(posedge clk); #1;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_if_last = 32'd0;
    exp_d_last  = 32'd0;
  endtask

  // One request from a single requester; cycle 0 is the first cycle req is high.
  task automatic run_access(input bit is_if, input bit we, input logic [31:0] a,
                            input logic [31:0] wd);
    bit          valid;
    int          exp_cyc;
    logic [31:0] exp_rd, exp_oth, own_rd, oth_rd;
    int          done_cyc, n_rd, n_wr, first_strb;
    bit          bad_addr, other_done;
    logic        err_s, busy_s;
    done_cyc = -1; n_rd = 0; n_wr = 0; first_strb = -1;
    bad_addr = 1'b0; other_done = 1'b0; err_s = 1'b0; busy_s = 1'b0;
    own_rd = 32'd0; oth_rd = 32'd0;
    valid   = model_valid(is_if, a);
    exp_cyc = valid ? 2 + W : 1;
    exp_oth = is_if ? exp_d_last : exp_if_last;
    if (!valid) exp_rd = 32'd0;
    else if (is_if) begin exp_rd = ref_mem[a[13:2]]; exp_if_last = exp_rd; end
    else if (we) begin ref_mem[a[13:2]] = wd; exp_rd = exp_d_last; end
    else begin exp_rd = ref_mem[a[13:2]]; exp_d_last = exp_rd; end

    @(posedge clk); #1;
    if_addr = is_if ? a : $urandom;
    d_addr  = is_if ? $urandom : a;
    d_we    = we;
    d_wdata = wd;
    if_req  = is_if;
    d_req   = !is_if;
    for (int c = 0; c < W + 12; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (first_strb < 0) first_strb = c;
        if (mem_addr !== a || (mem_write && mem_wdata !== wd)) bad_addr = 1'b1;
      end
      if (mem_read) n_rd++;
      if (mem_write) n_wr++;
      if (is_if ? d_done : if_done) other_done = 1'b1;
      if (is_if ? if_done : d_done) begin
        done_cyc = c;
        err_s    = err;
        busy_s   = busy;
        own_rd   = is_if ? if_rdata : d_rdata;
        oth_rd   = is_if ? d_rdata : if_rdata;
        break;
      end
    end
    chk("done_cycle", done_cyc, exp_cyc);
    chk("err", err_s, !valid);
    chk("rdata", own_rd, exp_rd);
    chk("read_cycles", n_rd, (valid && !we) ? W + 1 : 0);
    chk("write_cycles", n_wr, (valid && we) ? W + 1 : 0);
    chk("strobe_start", first_strb, valid ? 1 : -1);
    chk("strobe_addr_data", bad_addr, 1'b0);
    chk("other_done", other_done, 1'b0);
    chk("busy_in_done", busy_s, 1'b1);
    if (valid) chk("other_rdata", oth_rd, exp_oth);
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", {if_done, d_done}, 2'b00);
    chk("idle_after_done", busy, 1'b0);
  endtask

  bit          win_if, last_d, r_if, r_we, seen;
  int          got, prev;
  logic [31:0] r_a;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = pattern(i);
    exp_if_last = 32'd0;
    exp_d_last  = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_strobes_flags", {mem_read, mem_write, if_done, d_done, err, busy}, 6'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // Directed accesses and region boundaries
    run_access(1'b1, 1'b0, 32'h3000, 32'd0);
    run_access(1'b0, 1'b1, 32'h0010, 32'hDEADBEEF);
    run_access(1'b0, 1'b0, 32'h0010, 32'd0);
    run_access(1'b0, 1'b1, 32'h3000, 32'h12345678);
    run_access(1'b0, 1'b0, 32'h0002, 32'd0);
    run_access(1'b1, 1'b0, 32'h0FFC, 32'd0);
    run_access(1'b1, 1'b0, 32'h3FFC, 32'd0);
    run_access(1'b1, 1'b0, 32'h4000, 32'd0);
    run_access(1'b0, 1'b0, 32'h2FFC, 32'd0);
    run_access(1'b0, 1'b0, 32'h2FFD, 32'd0);
    run_access(1'b1, 1'b0, 32'h3002, 32'd0);

    // Simultaneous requests held across three grants
    reset_seq();
    @(posedge clk); #1;
    if_addr = 32'h3004; d_addr = 32'h0000; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    last_d = 1'b1; got = 0; prev = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        win_if = RR ? last_d : 1'b0;
        chk("arb_if_done", if_done, win_if);
        chk("arb_d_done", d_done, !win_if);
        chk("arb_rdata", win_if ? if_rdata : d_rdata, win_if ? ref_mem[12'hC01] : ref_mem[0]);
        chk("arb_cycle", c, (got == 0) ? 2 + W : prev + W + 3);
        if (win_if) exp_if_last = ref_mem[12'hC01];
        else exp_d_last = ref_mem[0];
        prev = c; last_d = !win_if; got++;
      end
    end
    chk("arb_grants", got, 3);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;

    // Reset in the second ACCESS cycle of a load
    @(posedge clk); #1;
    d_we = 1'b0; d_addr = 32'h0100; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_read_before", mem_read, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    if (d_done) seen = 1'b1;
    @(negedge clk);
    chk("abort_read_after", mem_read, 1'b0);
    chk("abort_busy_after", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b0;
    exp_if_last = 32'd0; exp_d_last = 32'd0;
    repeat (W + 3) begin
      @(negedge clk);
      if (d_done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    run_access(1'b0, 1'b0, 32'h0100, 32'd0);

    // Randomized single-requester traffic
    for (int k = 0; k < 40; k++) begin
      r_if = 1'($urandom_range(0, 1));
      r_we = r_if ? 1'b0 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1: r_a = 32'h100 + 32'(4 * $urandom_range(0, 7));
        2:    r_a = 32'($urandom_range(0, 32'h2FFF)) & 32'hFFFF_FFFC;
        3:    r_a = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) & 32'hFFFF_FFFC);
        4:    r_a = 32'($urandom_range(0, 32'h4003));
        default: r_a = $urandom;
      endcase
      run_access(r_if, r_we, r_a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
